// File: rtl/bsg_dff_reset_async.sv
// bsg_dff_reset_async: width_p-bit register bank with asynchronous active-high reset
module bsg_dff_reset_async #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);
  logic [width_p-1:0] data_q;
  logic [width_p-1:0] data_d;
  assign data_d = data_i;
  assign data_o = data_q;
  // capture data every rising edge; reset forces the reset value immediately
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) data_q <= reset_val_p;
    else         data_q <= data_d;
endmodule

// File: tb/tb_bsg_dff_reset_async.sv
// tb_bsg_dff_reset_async: directed checks of the async-reset register against a behavioural model
module tb_bsg_dff_reset_async;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] d = 40'hFF_FFFF_FFFF;
  logic [39:0] q;
  logic [7:0]  d8 = 8'hFF;
  logic [7:0]  q8;
  int          vectors = 0;
  int          miscompares = 0;
  logic        run = 1'b1;
  logic        rst_seen = 1'b1;
  logic [39:0] last_d = '0;
  logic [7:0]  last_d8 = '0;

  bsg_dff_reset_async #(.width_p(40)) dut40 (
    .clk_i(clk), .reset_i(reset), .data_i(d), .data_o(q));
  bsg_dff_reset_async #(.width_p(8), .reset_val_p(8'h5A)) dut8 (
    .clk_i(clk), .reset_i(reset), .data_i(d8), .data_o(q8));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // model: output is the reset value if reset was seen since the last edge,
  // otherwise whatever data_i held at that edge
  always @(posedge reset) rst_seen = 1'b1;
  always @(posedge clk) begin
    rst_seen = reset;
    last_d   = d;
    last_d8  = d8;
  end

  always @(negedge clk) begin
    #2;
    if (run) begin
      chk("model40", q, (rst_seen || reset) ? 40'h0 : last_d);
      chk("model8", {32'h0, q8}, (rst_seen || reset) ? 40'h5A : {32'h0, last_d8});
    end
  end

  initial begin
    repeat (3) begin
      step; #5;
      chk("rst40", q, 40'h0);
      chk("rst8", {32'h0, q8}, 40'h5A);
    end
    step;
    reset = 1'b0; d = 40'h1_0000_1234; d8 = 8'h00;
    #5;
    chk("hold40", q, 40'h0);
    chk("hold8", {32'h0, q8}, 40'h5A);
    step;
    d = 40'h0;
    #5;
    chk("first40", q, 40'h1_0000_1234);
    chk("first8", {32'h0, q8}, 40'h0);
    step; #5;
    chk("zero40", q, 40'h0);
    for (int i = 0; i < 256; i++) begin
      step;
      d = 40'(i);
      #5;
      chk("stream", q, (i == 0) ? 40'h0 : 40'(i - 1));
    end
    step;
    d = 40'hAB;
    step;
    chk("pre_async", q, 40'hAB);
    #2 reset = 1'b1;
    #1;
    chk("async40", q, 40'h0);
    chk("async8", {32'h0, q8}, 40'h5A);
    step;
    reset = 1'b0; d = 40'h3;
    step; #5;
    chk("three", q, 40'h3);
    @(posedge clk) reset = 1'b1;
    #2 reset = 1'b0;
    #5;
    chk("edge_rst", q, 40'h0);
    step; #5;
    chk("after_edge", q, 40'h3);
    step;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
